// File: rtl/s2p_pkg.sv
// Shared types and helpers for the serial-to-parallel capture sequencer.
// Build option S2P_PARITY_EN (used by s2p_frame_ctrl) adds a trailing even-parity bit per word.
package s2p_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } s2p_state_t;

   localparam int S2P_WORD_W    = 32;
   // Widest word the parity helper can cover; callers zero-extend into it.
   localparam int S2P_PAR_MAX_W = 64;

   function automatic logic even_parity(input logic [S2P_PAR_MAX_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/s2p_shifter.sv
// WORD_W-bit serial shift register. data_next is the value loaded on the coming edge,
// so the controller can capture a word on the same edge that samples its last bit.
module s2p_shifter #(
   parameter int WORD_W    = 32,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              shift_en,
   input  logic              clear,
   input  logic              bit_in,
   output logic [WORD_W-1:0] data_next
);

   logic [WORD_W-1:0] data_q;
   logic [WORD_W-1:0] base;

   // clear together with shift_en loads bit_in into an otherwise empty register
   always_comb begin
      base      = clear ? '0 : data_q;
      data_next = base;
      if (shift_en) begin
         if (MSB_FIRST) data_next = {base[WORD_W-2:0], bit_in};
         else           data_next = {bit_in, base[WORD_W-1:1]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) data_q <= '0;
      else       data_q <= data_next;
   end

endmodule

// File: rtl/s2p_frame_ctrl.sv
// Serial-to-parallel frame sequencer: word alignment, bit counting, holding register with
// valid/ready handshake and sticky fault flags. Define S2P_PARITY_EN for a per-word even-parity bit.
module s2p_frame_ctrl
   import s2p_pkg::*;
#(
   parameter int WORD_W    = S2P_WORD_W,
   parameter bit MSB_FIRST = 1'b1,
   localparam int CNT_W    = $clog2(WORD_W+1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              serial_in,
   input  logic              serial_valid,
   input  logic              frame_start,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [CNT_W-1:0]  bit_count,
   output logic              busy,
   output logic              overrun,
   output logic              align_err,
   output logic              parity_err,
   input  logic              clear_err
);

   s2p_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] word_q, done_word, sh_next;
   logic              valid_q, ovr_q, aln_q;
   logic              sh_en, sh_clr, set_align, word_done;
`ifdef S2P_PARITY_EN
   logic                     par_bit, set_par, par_q;
   logic [S2P_PAR_MAX_W-1:0] par_ext;
`else
   logic                     last_bit;
`endif

   s2p_shifter #(.WORD_W(WORD_W), .MSB_FIRST(MSB_FIRST)) u_shifter (
      .clk       (clk),
      .reset     (reset),
      .shift_en  (sh_en),
      .clear     (sh_clr),
      .bit_in    (serial_in),
      .data_next (sh_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, bit counter and shifter control. Completion is only strobed here so the
   // word/parity decision below can read sh_next without a combinational loop.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sh_en     = 1'b0;
      sh_clr    = 1'b0;
      set_align = 1'b0;
`ifdef S2P_PARITY_EN
      par_bit   = 1'b0;
`else
      last_bit  = 1'b0;
`endif
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         sh_clr  = 1'b1;
      end else if (serial_valid) begin
         case (state_q)
            IDLE: begin
               if (frame_start) begin
                  sh_clr  = 1'b1;
                  sh_en   = 1'b1;
                  cnt_d   = CNT_W'(1);
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               sh_en = 1'b1;
               if (frame_start && cnt_q != '0) begin
                  sh_clr    = 1'b1;
                  set_align = 1'b1;
                  cnt_d     = CNT_W'(1);
               end else if (cnt_q == CNT_W'(WORD_W-1)) begin
                  cnt_d = '0;
`ifdef S2P_PARITY_EN
                  state_d = PARITY;
`else
                  last_bit = 1'b1;
`endif
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
`ifdef S2P_PARITY_EN
            PARITY: begin
               state_d = SHIFT;
               if (frame_start) begin
                  sh_clr    = 1'b1;
                  sh_en     = 1'b1;
                  set_align = 1'b1;
                  cnt_d     = CNT_W'(1);
               end else begin
                  par_bit = 1'b1;
               end
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

`ifdef S2P_PARITY_EN
   // Shifter holds the data bits during PARITY, so sh_next is the finished word there.
   always_comb begin
      par_ext               = '0;
      par_ext[WORD_W-1:0]   = sh_next;
   end

   always_comb begin
      word_done = 1'b0;
      set_par   = 1'b0;
      done_word = sh_next;
      if (par_bit) begin
         if (even_parity(par_ext) == serial_in) word_done = 1'b1;
         else                                    set_par   = 1'b1;
      end
   end
`else
   always_comb begin
      word_done = last_bit;
      done_word = sh_next;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         aln_q   <= 1'b0;
      end else begin
         if (word_done && (!valid_q || word_ready)) begin
            word_q  <= done_word;
            valid_q <= 1'b1;
         end else if (valid_q && word_ready) begin
            valid_q <= 1'b0;
         end
         ovr_q <= (word_done && valid_q && !word_ready) | (ovr_q & ~clear_err);
         aln_q <= set_align | (aln_q & ~clear_err);
      end
   end

`ifdef S2P_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) par_q <= 1'b0;
      else       par_q <= set_par | (par_q & ~clear_err);
   end
   assign parity_err = par_q;
`else
   assign parity_err = 1'b0;
`endif

   assign word_out   = word_q;
   assign word_valid = valid_q;
   assign bit_count  = cnt_q;
   assign busy       = (state_q != IDLE);
   assign overrun    = ovr_q;
   assign align_err  = aln_q;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Self-checking bench for s2p_frame_ctrl (WORD_W=8, MSB first): directed scenarios plus
// randomized traffic, every cycle compared against a bit-queue reference model.
module tb_s2p_frame_ctrl;

   localparam int W   = 8;
   localparam bit MSB = 1'b1;

   logic         clk = 1'b0;
   logic         reset, enable, serial_in, serial_valid, frame_start, word_ready, clear_err;
   logic [W-1:0] word_out;
   logic         word_valid, busy, overrun, align_err, parity_err;
   logic [3:0]   bit_count;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   bit           m_in_frame, m_in_par, m_valid, m_ovr, m_aln, m_par;
   bit           mq[$];
   logic [W-1:0] m_word, m_saved;

   s2p_frame_ctrl #(.WORD_W(W), .MSB_FIRST(MSB)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .serial_in    (serial_in),
      .serial_valid (serial_valid),
      .frame_start  (frame_start),
      .word_out     (word_out),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .bit_count    (bit_count),
      .busy         (busy),
      .overrun      (overrun),
      .align_err    (align_err),
      .parity_err   (parity_err),
      .clear_err    (clear_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] pack_bits();
      logic [W-1:0] w;
      w = '0;
      for (int i = 0; i < W; i++) begin
         if (MSB) w[W-1-i] = mq[i];
         else     w[i]     = mq[i];
      end
      return w;
   endfunction

   task automatic model_reset();
      m_in_frame = 0; m_in_par = 0; m_valid = 0;
      m_ovr = 0; m_aln = 0; m_par = 0;
      m_word = '0; m_saved = '0;
      mq.delete();
   endtask

   // Applies the capture rules to the inputs sampled at the edge just taken.
   task automatic model_edge();
      bit           done, n_ovr, n_aln, n_par;
      logic [W-1:0] w;
      done = 0; n_ovr = 0; n_aln = 0; n_par = 0; w = '0;
      if (!enable) begin
         m_in_frame = 0; m_in_par = 0; mq.delete();
      end else if (serial_valid) begin
         if (!m_in_frame) begin
            if (frame_start) begin
               m_in_frame = 1; mq.delete(); mq.push_back(serial_in);
            end
         end else if (frame_start && (mq.size() != 0 || m_in_par)) begin
            n_aln = 1; m_in_par = 0; mq.delete(); mq.push_back(serial_in);
         end else if (m_in_par) begin
            m_in_par = 0;
            if (((^m_saved) ^ serial_in) == 1'b0) begin done = 1; w = m_saved; end
            else n_par = 1;
         end else begin
            mq.push_back(serial_in);
            if (mq.size() == W) begin
               w = pack_bits();
               mq.delete();
`ifdef S2P_PARITY_EN
               m_in_par = 1; m_saved = w;
`else
               done = 1;
`endif
            end
         end
      end
      if (done && m_valid && !word_ready) n_ovr = 1;
      else if (done) begin m_word = w; m_valid = 1; end
      else if (m_valid && word_ready) m_valid = 0;
      m_ovr = n_ovr | (m_ovr & !clear_err);
      m_aln = n_aln | (m_aln & !clear_err);
      m_par = n_par | (m_par & !clear_err);
   endtask

   task automatic check_all();
      chk("word_out",   32'(word_out),   32'(m_word));
      chk("word_valid", 32'(word_valid), 32'(m_valid));
      chk("bit_count",  32'(bit_count),  32'(mq.size()));
      chk("busy",       32'(busy),       32'(m_in_frame));
      chk("overrun",    32'(overrun),    32'(m_ovr));
      chk("align_err",  32'(align_err),  32'(m_aln));
      chk("parity_err", 32'(parity_err), 32'(m_par));
   endtask

   task automatic cyc(input bit en, input bit sv, input bit fs, input bit b,
                      input bit rdy, input bit clr);
      enable = en; serial_valid = sv; frame_start = fs; serial_in = b;
      word_ready = rdy; clear_err = clr;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      enable = 0; serial_valid = 0; frame_start = 0; serial_in = 0;
      word_ready = 0; clear_err = 0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_all();
      reset = 1'b0;
   endtask

   // Sends one word MSB-first (plus its correct parity bit when parity is built in).
   task automatic send_word(input logic [W-1:0] w, input bit fs, input bit rdy);
      logic [W-1:0] wv;
      wv = w;
      for (int i = 0; i < W; i++) cyc(1, 1, fs && (i == 0), wv[W-1-i], rdy, 0);
`ifdef S2P_PARITY_EN
      cyc(1, 1, 0, ^wv, rdy, 0);
`endif
   endtask

   initial begin
      logic [W-1:0] a5;
      a5 = 8'hA5;
      reset = 1'b1;
      #2;
      model_reset();
      check_all();

      // 1: single word, consumer stalled
      do_reset();
      send_word(8'hA5, 1, 0);
      chk("t1_word",  32'(word_out),   32'h0A5);
      chk("t1_valid", 32'(word_valid), 32'h1);
      chk("t1_count", 32'(bit_count),  32'h0);
      cyc(1, 0, 0, 0, 1, 0);
      chk("t1_drain", 32'(word_valid), 32'h0);

      // 2: back-to-back words with ready high
      do_reset();
      send_word(8'h3C, 1, 1);
      chk("t2_busy",  32'(busy), 32'h1);
      send_word(8'hC3, 0, 1);
      chk("t2_word",  32'(word_out), 32'h0C3);
      chk("t2_ovr",   32'(overrun),  32'h0);
      cyc(1, 0, 0, 0, 1, 0);

      // 3: overrun with a stalled consumer, then clear
      do_reset();
      send_word(8'h11, 1, 0);
      send_word(8'h22, 0, 0);
      chk("t3_word", 32'(word_out), 32'h011);
      chk("t3_ovr",  32'(overrun),  32'h1);
      cyc(1, 0, 0, 0, 0, 1);
      chk("t3_clr",  32'(overrun),  32'h0);

      // 4: frame_start mid-word realigns
      do_reset();
      for (int i = 0; i < 5; i++) cyc(1, 1, i == 0, 1'(i), 1, 0);
      chk("t4_cnt5", 32'(bit_count), 32'h5);
      send_word(8'h96, 1, 1);
      chk("t4_aln",  32'(align_err), 32'h1);
      chk("t4_word", 32'(word_out),  32'h096);

      // 5: reset mid-word, then unframed bits are ignored
      do_reset();
      for (int i = 0; i < 3; i++) cyc(1, 1, i == 0, 1, 1, 0);
      #3 reset = 1'b1;
      #1;
      model_reset();
      check_all();
      chk("t5_cnt", 32'(bit_count), 32'h0);
      #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1, 1, 0);
      chk("t5_idle", 32'(bit_count), 32'h0);

`ifdef S2P_PARITY_EN
      // 6: parity good then bad
      do_reset();
      for (int i = 0; i < W; i++) cyc(1, 1, i == 0, a5[W-1-i], 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      chk("t6_valid", 32'(word_valid), 32'h1);
      chk("t6_word",  32'(word_out),   32'h0A5);
      cyc(1, 0, 0, 0, 1, 0);
      for (int i = 0; i < W; i++) cyc(1, 1, 0, a5[W-1-i], 0, 0);
      cyc(1, 1, 0, 1, 0, 0);
      chk("t6_perr",  32'(parity_err), 32'h1);
      chk("t6_novld", 32'(word_valid), 32'h0);
`endif

      // randomized traffic
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         cyc($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 11) == 0, 1'($urandom), $urandom_range(0, 2) != 0,
             $urandom_range(0, 24) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
